// File: rtl/int_seq_pkg.sv
// Shared types and constants for the interrupt entry/exit sequencer.
package int_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        SAVE_PC,
        SAVE_ST,
        VECTOR,
        SERVICE,
        RETURN
    } state_e;

    localparam int EPC_REG_DEF = 29;
    localparam int EST_REG_DEF = 30;
    localparam int VEC_SHIFT   = 2;

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
// Purely combinational, zero latency, no backpressure.
module int_prio_enc #(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 5
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               vld_o,
    output logic [ID_W-1:0]    id_o
);

    always_comb begin
        vld_o = 1'b0;
        id_o  = '0;
        // Walk from the top down so the lowest set index is the last one written.
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                vld_o = 1'b1;
                id_o  = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_sequencer.sv
// Interrupt sequencer: stalls the core, saves PC/state into the register file, vectors fetch, and restores on iret.
// Entry: irq sampled in IDLE -> redirect 4 cycles later; exit: 1-cycle RETURN redirect. Core held via stall.
module int_sequencer
    import int_seq_pkg::*;
#(
    parameter int NUM_IRQ = 32,
    parameter int ID_W    = 5,
    parameter int EPC_REG = EPC_REG_DEF,
    parameter int EST_REG = EST_REG_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               gie,
    input  logic [31:0]        ivt_b_p,
    input  logic [31:0]        p_state,
    input  logic [31:0]        pc_from_reg,
    input  logic [31:0]        pc_cur,
    input  logic               iret,
    input  logic               core_we,
    input  logic [4:0]         core_waddr,
    input  logic [31:0]        core_wdata,
    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [31:0]        rf_wdata,
    output logic               stall,
    output logic               redirect_valid,
    output logic [31:0]        redirect_pc,
    output logic [ID_W-1:0]    current_int_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] irq_claim
);

    state_e            state_q, state_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [NUM_IRQ-1:0] pend;
    logic              pend_vld;
    logic [ID_W-1:0]   pend_id;
    logic [31:0]       vec_off;

    assign pend = irq & {NUM_IRQ{gie}};

    int_prio_enc #(
        .NUM_IRQ (NUM_IRQ),
        .ID_W    (ID_W)
    ) u_prio (
        .req_i (pend),
        .vld_o (pend_vld),
        .id_o  (pend_id)
    );

    assign vec_off        = 32'(id_q) << VEC_SHIFT;
    assign current_int_id = id_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        id_d           = id_q;
        rf_we          = core_we & rst;
        rf_waddr       = core_waddr;
        rf_wdata       = core_wdata;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        in_service     = 1'b0;
        irq_claim      = '0;

        unique case (state_q)
            IDLE: begin
                if (pend_vld) begin
                    id_d    = pend_id;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // In-flight write-back still retires through the passthrough.
                stall   = 1'b1;
                state_d = SAVE_PC;
            end
            SAVE_PC: begin
                stall    = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = 5'(EPC_REG);
                rf_wdata = pc_cur;
                state_d  = SAVE_ST;
            end
            SAVE_ST: begin
                stall    = 1'b1;
                rf_we    = 1'b1;
                rf_waddr = 5'(EST_REG);
                rf_wdata = p_state;
                state_d  = VECTOR;
            end
            VECTOR: begin
                stall          = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = ivt_b_p + vec_off;
                for (int i = 0; i < NUM_IRQ; i++) begin
                    irq_claim[i] = (id_q == ID_W'(i));
                end
                state_d = SERVICE;
            end
            SERVICE: begin
                in_service = 1'b1;
                if (iret) begin
                    state_d = RETURN;
                end
            end
            RETURN: begin
                stall          = 1'b1;
                in_service     = 1'b1;
                redirect_valid = 1'b1;
                redirect_pc    = pc_from_reg;
                state_d        = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios plus randomized traffic against a timeline model.
module tb_int_sequencer;

    logic        clk;
    logic        rst;
    logic [31:0] irq;
    logic        gie;
    logic [31:0] ivt_b_p;
    logic [31:0] p_state;
    logic [31:0] pc_from_reg;
    logic [31:0] pc_cur;
    logic        iret;
    logic        core_we;
    logic [4:0]  core_waddr;
    logic [31:0] core_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [4:0]  current_int_id;
    logic        in_service;
    logic [31:0] irq_claim;

    int errors = 0;
    int checks = 0;

    // Model: cycles elapsed since an entry was accepted (0 = none), service and return flags.
    int       m_age;
    bit       m_svc;
    bit       m_ret;
    int       m_id;

    int_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .irq            (irq),
        .gie            (gie),
        .ivt_b_p        (ivt_b_p),
        .p_state        (p_state),
        .pc_from_reg    (pc_from_reg),
        .pc_cur         (pc_cur),
        .iret           (iret),
        .core_we        (core_we),
        .core_waddr     (core_waddr),
        .core_wdata     (core_wdata),
        .rf_we          (rf_we),
        .rf_waddr       (rf_waddr),
        .rf_wdata       (rf_wdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .current_int_id (current_int_id),
        .in_service     (in_service),
        .irq_claim      (irq_claim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int lowest(input logic [31:0] v);
        int r;
        r = -1;
        for (int i = 31; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        m_age = 0;
        m_svc = 0;
        m_ret = 0;
        m_id  = 0;
    endtask

    task automatic check_model();
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic [31:0] e_claim;
        e_we    = core_we & rst;
        e_addr  = core_waddr;
        e_data  = core_wdata;
        e_claim = 32'h0;
        if (m_age == 2) begin
            e_we = 1'b1; e_addr = 5'd29; e_data = pc_cur;
        end else if (m_age == 3) begin
            e_we = 1'b1; e_addr = 5'd30; e_data = p_state;
        end
        if (m_age == 4) e_claim = 32'h1 << m_id;
        chk("rf_we",    32'(rf_we),    32'(e_we));
        chk("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        chk("rf_wdata", rf_wdata,      e_data);
        chk("stall",    32'(stall),    32'((m_age != 0) || m_ret));
        chk("redir_vld", 32'(redirect_valid), 32'((m_age == 4) || m_ret));
        if (m_ret)       chk("redir_pc_ret", redirect_pc, pc_from_reg);
        if (m_age == 4)  chk("redir_pc_vec", redirect_pc, ivt_b_p + 32'(m_id * 4));
        chk("irq_claim",  irq_claim, e_claim);
        chk("in_service", 32'(in_service), 32'(m_svc || m_ret));
        chk("cur_id",     32'(current_int_id), 32'(m_id));
    endtask

    task automatic model_update();
        if (!rst) begin
            model_reset();
        end else if (m_ret) begin
            m_ret = 0;
        end else if (m_svc) begin
            if (iret) begin
                m_svc = 0;
                m_ret = 1;
            end
        end else if (m_age == 4) begin
            m_age = 0;
            m_svc = 1;
        end else if (m_age > 0) begin
            m_age++;
        end else if ((irq & {32{gie}}) != 0) begin
            m_id  = lowest(irq & {32{gie}});
            m_age = 1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step();
        sample();
        adv();
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic rand_data();
        core_we     = 1'($urandom);
        core_waddr  = 5'($urandom);
        core_wdata  = $urandom;
        p_state     = $urandom;
        pc_from_reg = $urandom;
    endtask

    initial begin
        model_reset();
        rst = 1'b0; irq = '0; gie = 1'b0; ivt_b_p = '0; pc_cur = '0; iret = 1'b0;
        rand_data();
        core_we = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_rf_we", 32'(rf_we), 32'h0);
        chk("rst_claim", irq_claim, 32'h0);
        chk("rst_id",    32'(current_int_id), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        steps(2);

        // Single source irq[3]
        gie = 1'b1; ivt_b_p = 32'h1000; pc_cur = 32'h200; irq = 32'h8;
        step();                       // sampled in IDLE
        step();                       // DRAIN
        sample(); chk("epc_addr", 32'(rf_waddr), 32'd29); chk("epc_data", rf_wdata, 32'h200); adv();
        sample(); chk("est_addr", 32'(rf_waddr), 32'd30); chk("est_data", rf_wdata, p_state); adv();
        sample();
        chk("vec3_pc", redirect_pc, 32'h100C);
        chk("vec3_claim", irq_claim, 32'h8);
        chk("vec3_id", 32'(current_int_id), 32'd3);
        adv();
        irq = '0;
        rand_data(); steps(3);
        iret = 1'b1; step(); iret = 1'b0;
        steps(2);

        // Simultaneous 4 and 6: 4 first, then 6
        irq = 32'h50; pc_from_reg = 32'h200;
        steps(4);
        sample(); chk("vec4_id", 32'(current_int_id), 32'd4); adv();
        irq = 32'h40;
        steps(2);
        iret = 1'b1; step(); iret = 1'b0;
        sample(); chk("ret_pc", redirect_pc, 32'h200); chk("ret_vld", 32'(redirect_valid), 32'h1); adv();
        step();
        sample(); chk("next_id6", 32'(current_int_id), 32'd6); adv();
        irq = '0;
        steps(4);
        iret = 1'b1; step(); iret = 1'b0;
        steps(2);

        // gie low masks everything
        gie = 1'b0; irq = 32'hFFFF_FFFF;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            sample(); chk("gie0_stall", 32'(stall), 32'h0); adv();
        end

        // Vector address wraps
        gie = 1'b1; ivt_b_p = 32'hFFFF_FFF0; irq = 32'h8000_0000;
        steps(4);
        sample(); chk("wrap_pc", redirect_pc, 32'h0000_006C); adv();
        irq = '0;
        iret = 1'b1; step(); iret = 1'b0;
        steps(2);

        // No nesting during service of id 7
        irq = 32'h80;
        steps(5);
        irq = 32'h04;
        for (int i = 0; i < 5; i++) begin
            sample(); chk("nonest_stall", 32'(stall), 32'h0); chk("nonest_id", 32'(current_int_id), 32'd7); adv();
        end
        irq = '0;
        iret = 1'b1; step(); iret = 1'b0;
        steps(7);
        iret = 1'b1; step(); iret = 1'b0;
        steps(2);
        // iret in IDLE ignored
        iret = 1'b1;
        sample(); chk("idle_iret", 32'(redirect_valid), 32'h0); adv();
        iret = 1'b0;
        sample(); chk("idle_iret2", 32'(redirect_valid), 32'h0); adv();

        // Async reset in the middle of SAVE_ST
        irq = 32'h2;
        steps(3);
        sample();
        #2;
        rst = 1'b0; core_we = 1'b1; core_waddr = 5'd5; core_wdata = 32'h659; irq = '0;
        #1;
        chk("arst_stall", 32'(stall), 32'h0);
        chk("arst_rv",    32'(redirect_valid), 32'h0);
        chk("arst_isvc",  32'(in_service), 32'h0);
        chk("arst_we",    32'(rf_we), 32'h0);
        adv();
        rst = 1'b1;
        #1;
        chk("post_we",   32'(rf_we), 32'h1);
        chk("post_addr", 32'(rf_waddr), 32'd5);
        chk("post_data", rf_wdata, 32'h659);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            gie     = ($urandom_range(0, 3) != 0);
            irq     = ($urandom_range(0, 5) == 0) ? $urandom : 32'h0;
            ivt_b_p = $urandom;
            pc_cur  = $urandom;
            iret    = ($urandom_range(0, 7) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
